// File: rtl/kianv_muldiv_unit.sv
// rtl/kianv_muldiv_unit.sv - shared iterative RV32M/RV64M multiply/divide engine
// Operands are reduced to magnitudes on accept; sign is restored in the FIX cycle.
module kianv_muldiv_unit #(
    parameter int XLEN      = 32,
    parameter int MUL_BPC   = 2,
    parameter int DIV_BPC   = 1,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] MUL_LAST = CW'(XLEN / MUL_BPC - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(XLEN / DIV_BPC - 1);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic            is_div, is_rem, a_signed, b_signed, sa, sb, neg_in;
    logic            div_zero, overflow, mul_zero, corner, accept;
    logic [XLEN-1:0] abs_a, abs_b, corner_val;

    logic [2:0]        op_q;
    logic              neg_q, corner_q;
    logic [XLEN-1:0]   corner_val_q;
    logic [CW-1:0]     iter;
    logic [2*XLEN-1:0] acc, mcand, mul_part, prod_fix;
    logic [XLEN-1:0]   mplier, rem, quo, divisor;
    logic [XLEN:0]     div_r;
    logic [XLEN-1:0]   div_q, div_sel, div_fix, fix_val;

    always_comb begin
        is_div   = op[2];
        is_rem   = op[2] & op[1];
        a_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        b_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        sa       = a_signed & rs1[XLEN-1];
        sb       = b_signed & rs2[XLEN-1];
        abs_a    = sa ? -rs1 : rs1;
        abs_b    = sb ? -rs2 : rs2;
        neg_in   = is_rem ? sa : (sa ^ sb);
        div_zero = is_div && (rs2 == '0);
        overflow = is_div && !op[0] && (rs1 == MIN_INT) && (rs2 == '1);
        mul_zero = !is_div && ((rs1 == '0) || (rs2 == '0));
        corner   = div_zero | overflow | mul_zero;
        corner_val = '0;
        if (div_zero) begin
            corner_val = is_rem ? rs1 : '1;
        end else if (overflow) begin
            corner_val = is_rem ? '0 : MIN_INT;
        end
    end

    assign accept    = (state == S_IDLE) && in_valid && !flush;
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_MUL) || (state == S_DIV) || (state == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (corner && EARLY_OUT) begin
                        state_next = S_FIX;
                    end else begin
                        state_next = is_div ? S_DIV : S_MUL;
                    end
                end
            end
            S_MUL:   if (iter == '0) state_next = S_FIX;
            S_DIV:   if (iter == '0) state_next = S_FIX;
            S_FIX:   state_next = S_DONE;
            S_DONE:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (flush) begin
            state_next = S_IDLE;
        end
    end

    assign mul_part = mcand * {{(2*XLEN-MUL_BPC){1'b0}}, mplier[MUL_BPC-1:0]};

    // Restoring division: each step brings down one dividend bit into the remainder.
    always_comb begin
        div_r = {1'b0, rem};
        div_q = quo;
        for (int i = 0; i < DIV_BPC; i++) begin
            div_r = {div_r[XLEN-1:0], div_q[XLEN-1]};
            div_q = {div_q[XLEN-2:0], 1'b0};
            if (div_r >= {1'b0, divisor}) begin
                div_r    = div_r - {1'b0, divisor};
                div_q[0] = 1'b1;
            end
        end
    end

    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        div_sel  = op_q[1] ? rem : quo;
        div_fix  = neg_q ? -div_sel : div_sel;
        if (corner_q) begin
            fix_val = corner_val_q;
        end else if (op_q[2]) begin
            fix_val = div_fix;
        end else if (op_q == 3'd0) begin
            fix_val = prod_fix[XLEN-1:0];
        end else begin
            fix_val = prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q         <= '0;
            neg_q        <= 1'b0;
            corner_q     <= 1'b0;
            corner_val_q <= '0;
            iter         <= '0;
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            rem          <= '0;
            quo          <= '0;
            divisor      <= '0;
            result       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q         <= op;
                        neg_q        <= neg_in;
                        corner_q     <= corner;
                        corner_val_q <= corner_val;
                        iter         <= is_div ? DIV_LAST : MUL_LAST;
                        acc          <= '0;
                        mcand        <= {{XLEN{1'b0}}, abs_a};
                        mplier       <= abs_b;
                        rem          <= '0;
                        quo          <= abs_a;
                        divisor      <= abs_b;
                    end
                end
                S_MUL: begin
                    acc    <= acc + mul_part;
                    mcand  <= mcand << MUL_BPC;
                    mplier <= mplier >> MUL_BPC;
                    iter   <= iter - 1'b1;
                end
                S_DIV: begin
                    rem  <= div_r[XLEN-1:0];
                    quo  <= div_q;
                    iter <= iter - 1'b1;
                end
                S_FIX: begin
                    result <= fix_val;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kianv_muldiv_unit.sv
// tb/tb_kianv_muldiv_unit.sv - scoreboard bench for kianv_muldiv_unit
module tb_kianv_muldiv_unit;

    localparam logic [31:0] MIN = 32'h8000_0000;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [2:0]  op;
    logic [31:0] rs1, rs2, result;

    kianv_muldiv_unit #(
        .XLEN(32), .MUL_BPC(2), .DIV_BPC(1), .EARLY_OUT(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rs1(rs1), .rs2(rs2), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    bit   shown = 0;
    bit   after_hs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_model(logic [2:0] o, logic [31:0] a, logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (o)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return ONES;
                if (a == MIN && b == ONES) return MIN;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 32'h0) return ONES;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 32'h0) return a;
                if (a == MIN && b == ONES) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 32'h0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    function automatic int ref_lat(logic [2:0] o, logic [31:0] a, logic [31:0] b);
        if (o < 3'd4) return (a == 32'h0 || b == 32'h0) ? 2 : 18;
        if (b == 32'h0) return 2;
        if (o[0] == 1'b0 && a == MIN && b == ONES) return 2;
        return 34;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return ONES;
            3: return MIN;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compares every cycle the DUT presents a result against the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            if (after_hs) begin
                check("post_hs_out_valid", {31'h0, out_valid}, 32'h0);
                check("post_hs_in_ready", {31'h0, in_ready}, 32'h1);
                after_hs = 0;
            end
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    check("spurious_out_valid", {31'h0, out_valid}, 32'h0);
                end else begin
                    if (!shown) begin
                        check("latency", cyc - sbq[0].cyc, sbq[0].lat);
                        shown = 1;
                    end
                    check("result", result, sbq[0].res);
                    check("in_ready_in_done", {31'h0, in_ready}, 32'h0);
                    if (out_ready) begin
                        void'(sbq.pop_front());
                        shown = 0;
                        after_hs = 1;
                    end
                end
            end
        end
    end

    task automatic issue(logic [2:0] o, logic [31:0] a, logic [31:0] b);
        int n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("issue_in_ready", {31'h0, in_ready}, 32'h1);
        in_valid = 1'b1;
        op = o;
        rs1 = a;
        rs2 = b;
        e.res = ref_model(o, a, b);
        e.lat = ref_lat(o, a, b);
        e.cyc = cyc;
        sbq.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 3'($urandom);
        rs1 = $urandom;
        rs2 = $urandom;
    endtask

    task automatic complete(int hold);
        int n;
        n = 0;
        out_ready = 1'b0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("out_valid_timeout", {31'h0, out_valid}, 32'h1);
        if (!out_valid) begin
            sbq.delete();
            shown = 0;
            return;
        end
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    logic [2:0]  d_op[12]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd4, 3'd7, 3'd4, 3'd6, 3'd0};
    logic [31:0] d_a[12]   = '{32'd7, MIN, MIN, MIN, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                               32'd5, 32'd5, MIN, MIN, 32'h0001_2345};
    logic [31:0] d_b[12]   = '{32'hFFFF_FFFD, MIN, MIN, MIN, 32'd2, 32'd2, 32'd2,
                               32'd0, 32'd0, ONES, ONES, 32'h0000_6789};
    int          d_hold[12] = '{0, 1, 0, 2, 0, 1, 0, 0, 3, 0, 0, 10};

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        op = '0;
        rs1 = '0;
        rs2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_result", result, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            issue(d_op[i], d_a[i], d_b[i]);
            complete(d_hold[i]);
        end

        for (int i = 0; i < 60; i++) begin
            issue(3'($urandom_range(0, 7)), rand_operand(), rand_operand());
            complete($urandom_range(0, 3));
        end

        // Flush in the middle of a divide, with a competing request on the same cycle.
        issue(3'd4, 32'd1000, 32'd7);
        repeat (4) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        in_valid = 1'b1;
        op = 3'd0;
        rs1 = 32'd3;
        rs2 = 32'd4;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        sbq.delete();
        shown = 0;
        check("flush_in_ready", {31'h0, in_ready}, 32'h1);
        check("flush_out_valid", {31'h0, out_valid}, 32'h0);
        check("flush_busy", {31'h0, busy}, 32'h0);
        flush = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_idle_busy", {31'h0, busy}, 32'h0);
        check("flush_idle_in_ready", {31'h0, in_ready}, 32'h1);
        repeat (40) begin
            @(posedge clk); #1;
        end
        issue(3'd0, 32'd3, 32'd4);
        complete(0);

        // Asynchronous reset in the middle of a multiply.
        issue(3'd1, 32'h0123_4567, 32'h89AB_CDEF);
        repeat (5) begin
            @(posedge clk); #1;
        end
        #2;
        reset = 1'b1;
        #1;
        check("arst_in_ready", {31'h0, in_ready}, 32'h1);
        check("arst_out_valid", {31'h0, out_valid}, 32'h0);
        check("arst_result", result, 32'h0);
        check("arst_busy", {31'h0, busy}, 32'h0);
        sbq.delete();
        shown = 0;
        after_hs = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        issue(3'd6, 32'hFFFF_FFF9, 32'd2);
        complete(1);

        repeat (3) begin
            @(posedge clk); #1;
        end
        check("final_queue_empty", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
